req_dispatch_queue: RTL

- Parametrised successor to the two-channel AES/SHA request queue. Accepts decoded instructions from the deserializer and routes each one by opcode into one of NCH independent FIFOs.
- Each FIFO presents its head to its own FSM over a valid/ready handshake.
- Adds over the previous generation: per-channel occupancy and almost-full flags, per-channel flush, illegal-opcode rejection, and pop only on a true valid&&ready handshake.

---
 rtl/req_dispatch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/req_dispatch_queue.sv
// req_dispatch_queue: routes decoded instructions by opcode into NCH
// independent FIFOs, each presenting its head over a valid/ready handshake,
// with per-channel occupancy, almost-full flag and flush.
module req_dispatch_queue #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int NCH     = 2,
  parameter int QDEPTH  = 16,
  parameter int AFULL   = 12,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int IDXW   = $clog2(QDEPTH),
  localparam int INSTRW = 3*ADDRW + OPCODEW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [OPCODEW-1:0]        opcode,
  input  logic [ADDRW-1:0]          key_addr,
  input  logic [ADDRW-1:0]          text_addr,
  input  logic [ADDRW-1:0]          dest_addr,
  output logic [NCH*INSTRW-1:0]     instr_out,
  output logic [NCH-1:0]            valid_out,
  input  logic [NCH-1:0]            ready_in,
  input  logic [NCH-1:0]            flush,
  output logic [NCH*(IDXW+1)-1:0]   count,
  output logic [NCH-1:0]            almost_full,
  output logic                      err_illegal
);

  localparam logic [IDXW:0] QFULL  = (IDXW+1)'(QDEPTH);
  localparam logic [IDXW:0] AFLIM  = (IDXW+1)'(AFULL);
  localparam logic [CHW:0]  NCHLIM = (CHW+1)'(NCH);

  logic [INSTRW-1:0] r_mem [NCH][QDEPTH];
  logic [IDXW-1:0]   r_wrPtr [NCH];
  logic [IDXW-1:0]   r_rdPtr [NCH];
  logic [IDXW:0]     r_count [NCH];
  logic              r_errIllegal;

  logic [CHW-1:0]    w_sel;
  logic              w_legal;
  logic              w_selOk;
  logic [NCH-1:0]    w_push;
  logic [NCH-1:0]    w_pop;
  logic [INSTRW-1:0] w_entry;

  assign w_sel   = opcode[CHW-1:0];
  assign w_legal = ({1'b0, w_sel} < NCHLIM);
  assign w_entry = {opcode, key_addr, text_addr, dest_addr};

  // Selected channel can take an entry: not full and not being flushed.
  always_comb begin
    w_selOk = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (w_sel == CHW'(c)) w_selOk = (r_count[c] != QFULL) && !flush[c];
    end
  end

  assign ready_out = w_legal && w_selOk;

  // Per-channel push/pop strobes; a pop needs a non-empty FIFO.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int c = 0; c < NCH; c++) begin
      w_push[c] = valid_in && ready_out && (w_sel == CHW'(c));
      w_pop[c]  = (r_count[c] != '0) && ready_in[c];
    end
  end

  // Pointer and occupancy update; flush overrides push/pop on its channel.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst || flush[c]) begin
        r_wrPtr[c] <= '0;
        r_rdPtr[c] <= '0;
        r_count[c] <= '0;
      end else begin
        if (w_push[c]) r_wrPtr[c] <= r_wrPtr[c] + 1'b1;
        if (w_pop[c])  r_rdPtr[c] <= r_rdPtr[c] + 1'b1;
        case ({w_push[c], w_pop[c]})
          2'b10:   r_count[c] <= r_count[c] + 1'b1;
          2'b01:   r_count[c] <= r_count[c] - 1'b1;
          default: r_count[c] <= r_count[c];
        endcase
      end
    end
  end

  // Entry storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst && w_push[c]) r_mem[c][r_wrPtr[c]] <= w_entry;
    end
  end

  // Illegal-opcode pulse, one cycle after each offending cycle.
  always_ff @(posedge clk) begin
    if (rst) r_errIllegal <= 1'b0;
    else     r_errIllegal <= valid_in && !w_legal;
  end

  assign err_illegal = r_errIllegal;

  // Head, occupancy and flags per channel; head reads as zero when empty.
  always_comb begin
    instr_out   = '0;
    valid_out   = '0;
    count       = '0;
    almost_full = '0;
    for (int c = 0; c < NCH; c++) begin
      valid_out[c]                   = (r_count[c] != '0);
      count[c*(IDXW+1) +: (IDXW+1)]  = r_count[c];
      almost_full[c]                 = (r_count[c] >= AFLIM);
      instr_out[c*INSTRW +: INSTRW]  = (r_count[c] != '0) ? r_mem[c][r_rdPtr[c]] : '0;
    end
  end

endmodule
